// File: rtl/sap_2_accumulator_if.sv
`default_nettype none
// ============================================================================
// sap_2_accumulator_if : W-bus / ALU / stack signal bundle for sap_2_accumulator
// Optional: SAP_2_ACCUMULATOR_PARITY_FLAG_EN adds the registered parity flag P.
// Rev 1.0
// ============================================================================
interface sap_2_accumulator_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic             LAbar;
  logic             EA;
  logic [2:0]       op;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] s_a_out;
  logic [WIDTH-1:0] bus_out;
  logic             Z;
  logic             S;
  logic             Cy;
  logic             stk_full;
  logic             stk_empty;
  logic             err;
`ifdef SAP_2_ACCUMULATOR_PARITY_FLAG_EN
  logic             P;

  modport master (
    output in, LAbar, EA, op, push, pop,
    input  s_a_out, bus_out, Z, S, Cy, stk_full, stk_empty, err, P
  );

  modport slave (
    input  in, LAbar, EA, op, push, pop,
    output s_a_out, bus_out, Z, S, Cy, stk_full, stk_empty, err, P
  );
`else
  modport master (
    output in, LAbar, EA, op, push, pop,
    input  s_a_out, bus_out, Z, S, Cy, stk_full, stk_empty, err
  );

  modport slave (
    input  in, LAbar, EA, op, push, pop,
    output s_a_out, bus_out, Z, S, Cy, stk_full, stk_empty, err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/sap_2_accumulator.sv
`default_nettype none
// ============================================================================
// sap_2_accumulator : SAP accumulator with unary ALU, registered flags, LIFO save stack
// Optional: SAP_2_ACCUMULATOR_PARITY_FLAG_EN adds registered even-parity output P.
// Rev 1.0
// ============================================================================
module sap_2_accumulator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 3
) (
  input  wire logic          Clk,
  input  wire logic          Clr,
  sap_2_accumulator_if.slave bus
);

  localparam logic [2:0]       c_op_hold = 3'b000;
  localparam logic [2:0]       c_op_inc  = 3'b001;
  localparam logic [2:0]       c_op_dec  = 3'b010;
  localparam logic [2:0]       c_op_shl  = 3'b011;
  localparam logic [2:0]       c_op_shr  = 3'b100;
  localparam logic [2:0]       c_op_rcl  = 3'b101;
  localparam logic [2:0]       c_op_rol  = 3'b110;
  localparam logic [2:0]       c_op_cpl  = 3'b111;
  localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] c_ptr_one = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] c_ptr_max = PTR_W'(DEPTH);

  logic [WIDTH-1:0] r_acc;
  logic             r_z;
  logic             r_s;
  logic             r_cy;
  logic             r_err;
  logic [PTR_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_stk [DEPTH];

  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_cy_nxt;
  logic             w_z_nxt;
  logic             w_s_nxt;
  logic             w_err_nxt;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_flag_upd;
  logic             w_stk_wr;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_stk_top;

  assign w_full  = (r_ptr == c_ptr_max);
  assign w_empty = (r_ptr == '0);

  // Top of stack is the entry just below the pointer.
  always_comb begin
    w_stk_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ptr == PTR_W'(i + 1)) begin
        w_stk_top = r_stk[i];
      end
    end
  end

  always_comb begin
    w_acc_nxt  = r_acc;
    w_cy_nxt   = r_cy;
    w_ptr_nxt  = r_ptr;
    w_err_nxt  = 1'b0;
    w_flag_upd = 1'b0;
    w_stk_wr   = 1'b0;

    if (!bus.LAbar) begin
      w_acc_nxt  = bus.in;
      w_cy_nxt   = 1'b0;
      w_flag_upd = 1'b1;
    end else if (bus.push && bus.pop) begin
      w_err_nxt = 1'b1;
    end else if (bus.push) begin
      if (w_full) begin
        w_err_nxt = 1'b1;
      end else begin
        w_stk_wr  = 1'b1;
        w_ptr_nxt = r_ptr + c_ptr_one;
      end
    end else if (bus.pop) begin
      if (w_empty) begin
        w_err_nxt = 1'b1;
      end else begin
        w_acc_nxt  = w_stk_top;
        w_cy_nxt   = 1'b0;
        w_ptr_nxt  = r_ptr - c_ptr_one;
        w_flag_upd = 1'b1;
      end
    end else begin
      w_flag_upd = (bus.op != c_op_hold);
      case (bus.op)
        c_op_inc: begin
          w_acc_nxt = r_acc + c_one;
          w_cy_nxt  = &r_acc;
        end
        c_op_dec: begin
          w_acc_nxt = r_acc - c_one;
          w_cy_nxt  = (r_acc == '0);
        end
        c_op_shl: begin
          w_acc_nxt = {r_acc[WIDTH-2:0], 1'b0};
          w_cy_nxt  = r_acc[WIDTH-1];
        end
        c_op_shr: begin
          w_acc_nxt = {1'b0, r_acc[WIDTH-1:1]};
          w_cy_nxt  = r_acc[0];
        end
        c_op_rcl: begin
          w_acc_nxt = {r_acc[WIDTH-2:0], r_cy};
          w_cy_nxt  = r_acc[WIDTH-1];
        end
        c_op_rol: begin
          w_acc_nxt = {r_acc[WIDTH-2:0], r_acc[WIDTH-1]};
          w_cy_nxt  = r_acc[WIDTH-1];
        end
        c_op_cpl: begin
          w_acc_nxt = ~r_acc;
          w_cy_nxt  = 1'b0;
        end
        default: begin
          w_acc_nxt = r_acc;
          w_cy_nxt  = r_cy;
        end
      endcase
    end

    w_z_nxt = w_flag_upd ? (w_acc_nxt == '0)     : r_z;
    w_s_nxt = w_flag_upd ? w_acc_nxt[WIDTH-1]    : r_s;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_acc <= '0;
      r_z   <= 1'b0;
      r_s   <= 1'b0;
      r_cy  <= 1'b0;
      r_err <= 1'b0;
      r_ptr <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      r_z   <= w_z_nxt;
      r_s   <= w_s_nxt;
      r_cy  <= w_cy_nxt;
      r_err <= w_err_nxt;
      r_ptr <= w_ptr_nxt;
    end
  end

  // Stack storage carries no reset; Clr only blocks a write on the same edge.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stk
      always_ff @(posedge Clk) begin
        if (w_stk_wr && !Clr && (r_ptr == PTR_W'(gi))) begin
          r_stk[gi] <= r_acc;
        end
      end
    end
  endgenerate

`ifdef SAP_2_ACCUMULATOR_PARITY_FLAG_EN
  logic r_p;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_p <= 1'b0;
    end else if (w_flag_upd) begin
      r_p <= ^w_acc_nxt;
    end
  end

  assign bus.P = r_p;
`endif

  assign bus.s_a_out   = r_acc;
  assign bus.bus_out   = bus.EA ? r_acc : {WIDTH{1'bz}};
  assign bus.Z         = r_z;
  assign bus.S         = r_s;
  assign bus.Cy        = r_cy;
  assign bus.err       = r_err;
  assign bus.stk_full  = w_full;
  assign bus.stk_empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_sap_2_accumulator.sv
`default_nettype none
// ============================================================================
// tb_sap_2_accumulator : scoreboard bench for sap_2_accumulator (WIDTH=8, DEPTH=4)
// Rev 1.0
// ============================================================================
module tb_sap_2_accumulator;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  sap_2_accumulator_if #(.WIDTH(WIDTH)) bif ();

  sap_2_accumulator #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (3)
  ) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bif)
  );

  typedef struct {
    string tag;
    int    acc;
    bit    z;
    bit    s;
    bit    cy;
    bit    p;
    bit    full;
    bit    empty;
    bit    err;
    bit    ea;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: plain integers and a queue as the stack.
  int   m_acc;
  bit   m_z, m_s, m_cy, m_p;
  int   m_stk[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_z   = 1'b0;
    m_s   = 1'b0;
    m_cy  = 1'b0;
    m_p   = 1'b0;
    m_stk.delete();
  endtask

  task automatic step(input string tag, input logic [7:0] d, input logic la,
                      input logic [2:0] o, input logic pu, input logic po, input logic e);
    exp_t        x;
    bit          upd;
    bit          er;
    int          t;
    logic [7:0]  tv;
    @(negedge clk);
    bif.in    = d;
    bif.LAbar = la;
    bif.op    = o;
    bif.push  = pu;
    bif.pop   = po;
    bif.EA    = e;

    upd = 1'b0;
    er  = 1'b0;
    if (!la) begin
      m_acc = int'(d);
      m_cy  = 1'b0;
      upd   = 1'b1;
    end else if (pu && po) begin
      er = 1'b1;
    end else if (pu) begin
      if (m_stk.size() == DEPTH) er = 1'b1;
      else m_stk.push_back(m_acc);
    end else if (po) begin
      if (m_stk.size() == 0) er = 1'b1;
      else begin
        m_acc = m_stk.pop_back();
        m_cy  = 1'b0;
        upd   = 1'b1;
      end
    end else begin
      upd = (o != 3'd0);
      case (o)
        3'd1: begin t = m_acc + 1; m_cy = (t > 255); m_acc = t % 256; end
        3'd2: begin m_cy = (m_acc == 0); m_acc = (m_acc + 255) % 256; end
        3'd3: begin m_cy = (m_acc >= 128); m_acc = (m_acc * 2) % 256; end
        3'd4: begin m_cy = (m_acc % 2 == 1); m_acc = m_acc / 2; end
        3'd5: begin t = m_acc * 2 + int'(m_cy); m_cy = (t >= 256); m_acc = t % 256; end
        3'd6: begin m_cy = (m_acc >= 128); m_acc = (m_acc * 2) % 256 + int'(m_cy); end
        3'd7: begin m_acc = 255 - m_acc; m_cy = 1'b0; end
        default: ;
      endcase
    end
    if (upd) begin
      tv  = m_acc[7:0];
      m_z = (m_acc == 0);
      m_s = (m_acc >= 128);
      m_p = ($countones(tv) % 2 == 1);
    end

    x.tag   = tag;
    x.acc   = m_acc;
    x.z     = m_z;
    x.s     = m_s;
    x.cy    = m_cy;
    x.p     = m_p;
    x.full  = (m_stk.size() == DEPTH);
    x.empty = (m_stk.size() == 0);
    x.err   = er;
    x.ea    = e;
    sb.push_back(x);
  endtask

  task automatic idle(input string tag, input logic e);
    step(tag, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, e);
  endtask

  task automatic load(input string tag, input logic [7:0] d);
    step(tag, d, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: one expectation per edge following a stimulus step.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, " acc"},   32'(bif.s_a_out),   32'(e.acc));
        chk({e.tag, " Z"},     32'(bif.Z),         32'(e.z));
        chk({e.tag, " S"},     32'(bif.S),         32'(e.s));
        chk({e.tag, " Cy"},    32'(bif.Cy),        32'(e.cy));
        chk({e.tag, " err"},   32'(bif.err),       32'(e.err));
        chk({e.tag, " full"},  32'(bif.stk_full),  32'(e.full));
        chk({e.tag, " empty"}, 32'(bif.stk_empty), 32'(e.empty));
`ifdef SAP_2_ACCUMULATOR_PARITY_FLAG_EN
        chk({e.tag, " P"},     32'(bif.P),         32'(e.p));
`endif
        if (e.ea) begin
          chk({e.tag, " bus"}, 32'(bif.bus_out), 32'(e.acc));
        end else begin
          // Two-state simulators render an undriven bus as zero.
          n_checks++;
          if (!(bif.bus_out === 8'hzz || bif.bus_out === 8'h00)) begin
            n_fail++;
            $display("FAIL %s bus_hiz: got %h expected zz", e.tag, bif.bus_out);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] rd;
    logic       rla, rpu, rpo, rea;
    logic [2:0] rop;
    int         r;

    clr       = 1'b1;
    bif.in    = '0;
    bif.LAbar = 1'b1;
    bif.EA    = 1'b0;
    bif.op    = 3'd0;
    bif.push  = 1'b0;
    bif.pop   = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("rst acc",   32'(bif.s_a_out),   32'h0);
    chk("rst Z",     32'(bif.Z),         32'h0);
    chk("rst S",     32'(bif.S),         32'h0);
    chk("rst Cy",    32'(bif.Cy),        32'h0);
    chk("rst err",   32'(bif.err),       32'h0);
    chk("rst full",  32'(bif.stk_full),  32'h0);
    chk("rst empty", 32'(bif.stk_empty), 32'h1);

    load("ld_aa", 8'hAA);
    idle("bus_on", 1'b1);
    idle("bus_off", 1'b0);

    load("ld_ff", 8'hFF);
    step("inc_wrap", 8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    step("dec_wrap", 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);

    load("ld_81", 8'h81);
    step("shl", 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    step("rcl", 8'h00, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    load("ld_81b", 8'h81);
    step("rol", 8'h00, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    step("shr", 8'h00, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    step("cpl", 8'h00, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      rd = 8'(i * 8'h11);
      load("ld_stk", rd);
      step("push", 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    end
    step("push_full", 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    idle("err_clear", 1'b0);
    for (int i = 0; i < 4; i++) step("pop", 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1);
    step("pop_empty", 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1);
    idle("err_clear2", 1'b1);

    step("prio_load", 8'h5A, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    step("push_pop", 8'h00, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    idle("after_pp", 1'b0);

    step("push_a", 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    step("push_b", 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    load("ld_7e", 8'h7E);
    step("ack_err", 8'h00, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    idle("pre_rst", 1'b0);
    drain();
    chk("pre_rst acc", 32'(bif.s_a_out), 32'h7E);

    @(negedge clk);
    #1 clr = 1'b1;
    #1;
    chk("arst acc",   32'(bif.s_a_out),   32'h0);
    chk("arst Z",     32'(bif.Z),         32'h0);
    chk("arst S",     32'(bif.S),         32'h0);
    chk("arst Cy",    32'(bif.Cy),        32'h0);
    chk("arst err",   32'(bif.err),       32'h0);
    chk("arst empty", 32'(bif.stk_empty), 32'h1);
    chk("arst full",  32'(bif.stk_full),  32'h0);
    #1 clr = 1'b0;
    model_reset();

    for (int n = 0; n < 400; n++) begin
      rd  = 8'($urandom);
      rop = 3'($urandom_range(0, 7));
      rea = 1'($urandom);
      rla = ($urandom_range(0, 99) >= 12);
      r   = $urandom_range(0, 99);
      rpu = (r < 30);
      rpo = (r < 3) || (r >= 30 && r < 55);
      step("rnd", rd, rla, rop, rpu, rpo, rea);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sap_2_accumulator.md
Name: sap_2_accumulator

Overview:
- Parametrised next-generation accumulator for the SAP CPU datapath.
- Keeps the SAP-1 contract:
  - active-low load from the W bus;
  - continuous output to the adder/subtractor;
  - tri-state drive back onto the W bus.
- Adds width generalisation, in-place unary ALU operations with registered flags, and a DEPTH-entry LIFO save stack (push/pop) for subroutine scratch.

Parameters:
- WIDTH, 8, accumulator/bus width in bits (min 2).
- DEPTH, 4, save-stack entries (min 1).
- PTR_W, 3, stack pointer width; must satisfy 2^PTR_W > DEPTH.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Clr  input  1  asynchronous active-high reset.
- in  input  WIDTH  data from W bus.
- LAbar  input  1  active-low load strobe.
- EA  input  1  bus output enable.
- op  input  3  unary operation select.
- push  input  1  save acc onto stack.
- pop  input  1  restore acc from stack.
- s_a_out  output  WIDTH  acc, always driven, to adder/subtractor.
- bus_out  output  WIDTH  acc when EA=1, else high-Z.
- Z  output  1  zero flag (registered).
- S  output  1  sign flag = acc MSB (registered).
- Cy  output  1  carry/borrow/shift-out flag (registered).
- stk_full  output  1  stack holds DEPTH entries.
- stk_empty  output  1  stack holds 0 entries.
- err  output  1  one-cycle pulse on an illegal stack request.

Behaviour:
- Reset (Clr=1, async, immediate):
  - acc=0, Z=0, S=0, Cy=0, err=0;
  - stack pointer=0, so stk_empty=1 and stk_full=0;
  - stack contents don't-care.
- Reset asserted mid-operation aborts that cycle's update; no partial writes.
- s_a_out = acc combinationally.
- bus_out = EA ? acc : all Z. EA has no effect on state.
- One action per rising edge, in strict priority:
  1. LAbar=0: acc<=in. push, pop and op are ignored.
  2. push=1 and pop=1: no state change; err<=1.
  3. push=1:
     - not full: stack[ptr]<=acc, ptr<=ptr+1; acc and flags unchanged.
     - full: ignored; err<=1.
  4. pop=1:
     - not empty: acc<=stack[ptr-1], ptr<=ptr-1.
     - empty: ignored; err<=1.
  5. Otherwise execute op (all results WIDTH bits, wrap-around):
     - 000 hold; flags unchanged.
     - 001 inc: acc+1; Cy=carry out (1 on all-ones to 0).
     - 010 dec: acc-1; Cy=borrow (1 on 0 to all-ones).
     - 011 shl: Cy<=MSB, LSB<=0.
     - 100 shr: Cy<=LSB, MSB<=0.
     - 101 rol through carry: {Cy,acc}<={acc,Cy}.
     - 110 rol: MSB wraps to LSB; Cy<=old MSB.
     - 111 cpl: acc<=~acc.
- Flag update rules:
  - Z and S are recomputed from the new acc on load, successful pop, and every op except hold.
  - Cy is cleared on load, successful pop and cpl.
  - Cy, Z and S are unchanged on push, on an ignored request, and on hold.
- err is registered: high for exactly the cycle after an illegal request, then 0. It is not sticky.
- stk_full and stk_empty are decoded from the registered pointer and are valid the cycle after a push/pop.
- DEPTH=1 case: one push fills the stack, one pop empties it.

Optional Feature:
- Macro: SAP_2_ACCUMULATOR_PARITY_FLAG_EN.
- Defined:
  - adds output port P (1 bit), even parity of acc, registered;
  - P updates under exactly the same rules as Z and S;
  - reset value 0.
- Undefined: port P is absent; all other behaviour is identical.

Test Plan (WIDTH=8, DEPTH=4):
1. Load and bus drive:
   - Clr pulse, then in=8'hAA, LAbar=0 for one edge, then EA=1 → s_a_out=8'hAA, bus_out=8'hAA, S=1, Z=0.
   - EA=0 → bus_out=8'hzz.
2. Increment wrap: load 8'hFF, op=001 → acc=8'h00, Z=1, Cy=1, S=0.
   - Then op=010 → acc=8'hFF, Cy=1, S=1.
3. Shifts and rotates from acc=8'h81, Cy=0:
   - shl → acc=8'h02, Cy=1.
   - Then rol through carry → acc=8'h05, Cy=0.
   - Reload 8'h81, rol → acc=8'h03, Cy=1.
4. Stack LIFO:
   - Push 8'h11, 8'h22, 8'h33, 8'h44 → stk_full=1.
   - Fifth push → err pulses 1 for one cycle; state unchanged.
   - Four pops → acc=8'h44, then 8'h33, 8'h22, 8'h11; stk_empty=1.
   - Fifth pop → err=1 and acc stays 8'h11.
5. Priority:
   - LAbar=0 with push=1 and in=8'h5A → acc=8'h5A, pointer unchanged, err=0.
   - push=pop=1 → err=1, no change.
6. Async reset mid-stream: after two pushes and acc=8'h7E, assert Clr between edges → acc, flags and err go to 0 and stk_empty=1 immediately, without waiting for a Clk edge.
